// File: rtl/i2s_transmitter.sv
// I2S (Philips format) transmitter.
// Serialises stereo sample pairs onto sdata/lrck using the sclk level from the
// upstream clock divider. Everything runs on clk_in; sclk falling edges are
// detected internally and all serial outputs change in the cycle after a fall.
module i2s_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  lrck,
  output logic                  sdata,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int FRAME_LEN = 2 * SLOT_WIDTH;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] C_SLOT = CW'(SLOT_WIDTH);

  logic                  sclk_d;
  logic                  fall;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic [CW-1:0]         cnt_after;
  logic                  frame_load;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [DATA_WIDTH-1:0] frame_left;
  logic [DATA_WIDTH-1:0] frame_right;
  logic [DATA_WIDTH-1:0] load_left;
  logic [DATA_WIDTH-1:0] load_right;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_shifted;
  logic [CW-1:0]         pos;
  logic                  bit_next;
  logic                  lrck_next;

  assign fall       = sclk_d & ~sclk;
  assign cnt_next   = (cnt == C_LAST) ? '0 : cnt + 1'b1;
  assign cnt_after  = (cnt_next == C_LAST) ? '0 : cnt_next + 1'b1;
  assign frame_load = fall & (cnt_next == '0);
  assign lrck_next  = (cnt_after >= C_SLOT);

  // Frame contents for the bit about to be driven: on a load, the new frame
  // (holding register or silence) must already be visible so the left MSB
  // goes out on the same fall.
  always_comb begin
    load_left  = frame_left;
    load_right = frame_right;
    if (frame_load) begin
      load_left  = in_ready ? '0 : hold_left;
      load_right = in_ready ? '0 : hold_right;
    end
  end

  // Select the slot word and position; positions past DATA_WIDTH shift the
  // word out entirely, which yields the zero padding for free.
  always_comb begin
    word = load_left;
    pos  = cnt_next;
    if (cnt_next >= C_SLOT) begin
      word = load_right;
      pos  = cnt_next - C_SLOT;
    end
    word_shifted = word << pos;
    bit_next     = word_shifted[DATA_WIDTH-1];
  end

  // sclk edge detector
  always_ff @(posedge clk_in) begin
    if (reset) sclk_d <= 1'b0;
    else       sclk_d <= sclk;
  end

  // Bit counter, serial outputs and frame-level pulses, advanced on sclk falls
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt         <= C_LAST;
      sdata       <= 1'b0;
      lrck        <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall) begin
        cnt         <= cnt_next;
        sdata       <= bit_next;
        lrck        <= lrck_next;
        frame_left  <= load_left;
        frame_right <= load_right;
        if (frame_load) begin
          frame_start <= 1'b1;
          underrun    <= in_ready;
        end
      end
    end
  end

  // Holding register handshake; a transfer implies the register was empty, so
  // it can never collide with a load that empties it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      in_ready   <= 1'b1;
      hold_left  <= '0;
      hold_right <= '0;
    end else if (in_valid && in_ready) begin
      hold_left  <= in_left;
      hold_right <= in_right;
      in_ready   <= 1'b0;
    end else if (frame_load && !in_ready) begin
      in_ready   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: a 16-bit-word instance and a 12-bit-word
// instance share clock, reset and a divide-by-8 sclk.
module tb_i2s_transmitter;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        sclk_run = 1'b1;
  int          div_cnt = 0;

  logic [15:0] l16, r16;
  logic        v16, rdy16, lrck16, sd16, fs16, ur16;
  logic [11:0] l12, r12;
  logic        v12, rdy12, lrck12, sd12, fs12, ur12;

  int vectors = 0;
  int miscompares = 0;

  i2s_transmitter #(.DATA_WIDTH(16), .SLOT_WIDTH(16)) dut16 (
    .clk_in(clk_in), .reset(reset), .sclk(sclk),
    .in_left(l16), .in_right(r16), .in_valid(v16), .in_ready(rdy16),
    .lrck(lrck16), .sdata(sd16), .frame_start(fs16), .underrun(ur16)
  );

  i2s_transmitter #(.DATA_WIDTH(12), .SLOT_WIDTH(16)) dut12 (
    .clk_in(clk_in), .reset(reset), .sclk(sclk),
    .in_left(l12), .in_right(r12), .in_valid(v12), .in_ready(rdy12),
    .lrck(lrck12), .sdata(sd12), .frame_start(fs12), .underrun(ur12)
  );

  always #5 clk_in = ~clk_in;

  // Upstream clock divider: sclk is a registered level toggling every 4 clocks
  always @(posedge clk_in) begin
    if (sclk_run) begin
      if (div_cnt == 3) begin
        div_cnt <= 0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  // Returns at the negedge where outputs reflect the next sclk fall
  task automatic wait_fall();
    logic prev;
    int   n;
    prev = sclk;
    n = 0;
    forever begin
      @(negedge clk_in);
      if (prev && !sclk) break;
      prev = sclk;
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL fall_timeout: no sclk fall within 50 cycles, want one");
        return;
      end
    end
    @(negedge clk_in);
  endtask

  // One-cycle reset placed in an sclk low phase so no fall is hidden by it
  task automatic do_reset();
    wait_fall();
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic push(input bit sel, input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    if (sel) begin l12 = l[11:0]; r12 = r[11:0]; v12 = 1'b1; end
    else     begin l16 = l;       r16 = r;       v16 = 1'b1; end
    while (!(sel ? rdy12 : rdy16) && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready never rose, want 1");
    end
    @(negedge clk_in);
    v12 = 1'b0;
    v16 = 1'b0;
    vectors++;
    if ((sel ? rdy12 : rdy16) !== 1'b0) begin
      miscompares++;
      $display("FAIL push_ready_drop: in_ready=%b want 0", sel ? rdy12 : rdy16);
    end
  endtask

  task automatic test_reset();
    push(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (20) wait_fall();
    push(1'b0, 16'hFFFF, 16'hFFFF);
    do_reset();
    vectors++; if (rdy16 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", rdy16); end
    vectors++; if (lrck16 !== 1'b0) begin miscompares++; $display("FAIL reset_lrck: got %b want 0", lrck16); end
    vectors++; if (sd16 !== 1'b0) begin miscompares++; $display("FAIL reset_sdata: got %b want 0", sd16); end
    vectors++; if (fs16 !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start: got %b want 0", fs16); end
    vectors++; if (ur16 !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %b want 0", ur16); end
    vectors++; if (rdy12 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready12: got %b want 1", rdy12); end
  endtask

  task automatic test_frame_pattern();
    logic [31:0] exp_frame;
    logic        exp_lrck;
    exp_frame = 32'hA5C3_0F0F;
    do_reset();
    push(1'b0, 16'hA5C3, 16'h0F0F);
    for (int i = 0; i < 32; i++) begin
      wait_fall();
      exp_lrck = (((i + 1) % 32) >= 16);
      vectors++; if (sd16 !== exp_frame[31-i]) begin miscompares++; $display("FAIL pattern_sdata fall %0d: got %b want %b", i, sd16, exp_frame[31-i]); end
      vectors++; if (lrck16 !== exp_lrck) begin miscompares++; $display("FAIL pattern_lrck fall %0d: got %b want %b", i, lrck16, exp_lrck); end
      vectors++; if (fs16 !== (i == 0)) begin miscompares++; $display("FAIL pattern_frame_start fall %0d: got %b want %b", i, fs16, (i == 0)); end
      vectors++; if (ur16 !== 1'b0) begin miscompares++; $display("FAIL pattern_underrun fall %0d: got %b want 0", i, ur16); end
      if (i == 0) begin
        vectors++; if (rdy16 !== 1'b1) begin miscompares++; $display("FAIL pattern_ready_after_load: got %b want 1", rdy16); end
      end
    end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      wait_fall();
      vectors++; if (sd16 !== 1'b0) begin miscompares++; $display("FAIL underrun_sdata fall %0d: got %b want 0", i, sd16); end
      vectors++; if (ur16 !== ((i % 32) == 0)) begin miscompares++; $display("FAIL underrun_pulse fall %0d: got %b want %b", i, ur16, ((i % 32) == 0)); end
      vectors++; if (rdy16 !== 1'b1) begin miscompares++; $display("FAIL underrun_in_ready fall %0d: got %b want 1", i, rdy16); end
      if ((i % 32) == 0) begin
        @(negedge clk_in);
        vectors++; if (ur16 !== 1'b0) begin miscompares++; $display("FAIL underrun_width fall %0d: got %b want 0", i, ur16); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f1;
    logic [31:0] f2;
    f1 = 32'h1234_8001;
    f2 = 32'h7FFE_C0DE;
    do_reset();
    push(1'b0, f1[31:16], f1[15:0]);
    l16 = f2[31:16];
    r16 = f2[15:0];
    v16 = 1'b1;
    wait_fall();
    vectors++; if (sd16 !== f1[31]) begin miscompares++; $display("FAIL b2b_first_msb: got %b want %b", sd16, f1[31]); end
    vectors++; if (ur16 !== 1'b0) begin miscompares++; $display("FAIL b2b_frame0_underrun: got %b want 0", ur16); end
    vectors++; if (fs16 !== 1'b1) begin miscompares++; $display("FAIL b2b_frame0_start: got %b want 1", fs16); end
    vectors++; if (rdy16 !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_load: got %b want 1", rdy16); end
    @(negedge clk_in);
    vectors++; if (rdy16 !== 1'b0) begin miscompares++; $display("FAIL b2b_p2_accept: in_ready=%b want 0", rdy16); end
    v16 = 1'b0;
    for (int i = 1; i < 32; i++) begin
      wait_fall();
      vectors++; if (sd16 !== f1[31-i]) begin miscompares++; $display("FAIL b2b_p1_sdata fall %0d: got %b want %b", i, sd16, f1[31-i]); end
    end
    for (int i = 0; i < 32; i++) begin
      wait_fall();
      vectors++; if (sd16 !== f2[31-i]) begin miscompares++; $display("FAIL b2b_p2_sdata fall %0d: got %b want %b", i, sd16, f2[31-i]); end
      vectors++; if (ur16 !== 1'b0) begin miscompares++; $display("FAIL b2b_p2_underrun fall %0d: got %b want 0", i, ur16); end
      vectors++; if (fs16 !== (i == 0)) begin miscompares++; $display("FAIL b2b_p2_frame_start fall %0d: got %b want %b", i, fs16, (i == 0)); end
    end
  endtask

  task automatic test_narrow_word();
    logic [31:0] exp_frame;
    logic        exp_lrck;
    exp_frame = 32'b1111_1111_1111_0000_1000_0000_0001_0000;
    do_reset();
    push(1'b1, 16'h0FFF, 16'h0801);
    for (int i = 0; i < 32; i++) begin
      wait_fall();
      exp_lrck = (((i + 1) % 32) >= 16);
      vectors++; if (sd12 !== exp_frame[31-i]) begin miscompares++; $display("FAIL narrow_sdata fall %0d: got %b want %b", i, sd12, exp_frame[31-i]); end
      vectors++; if (lrck12 !== exp_lrck) begin miscompares++; $display("FAIL narrow_lrck fall %0d: got %b want %b", i, lrck12, exp_lrck); end
      vectors++; if (fs12 !== (i == 0)) begin miscompares++; $display("FAIL narrow_frame_start fall %0d: got %b want %b", i, fs12, (i == 0)); end
      vectors++; if (ur12 !== 1'b0) begin miscompares++; $display("FAIL narrow_underrun fall %0d: got %b want 0", i, ur12); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] new_left;
    new_left = 16'hB000;
    do_reset();
    push(1'b0, 16'h1111, 16'h2222);
    wait_fall();
    push(1'b0, 16'h3C3C, 16'h4444);
    for (int i = 1; i < 8; i++) wait_fall();
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    vectors++; if (sd16 !== 1'b0) begin miscompares++; $display("FAIL midreset_sdata: got %b want 0", sd16); end
    vectors++; if (lrck16 !== 1'b0) begin miscompares++; $display("FAIL midreset_lrck: got %b want 0", lrck16); end
    vectors++; if (rdy16 !== 1'b1) begin miscompares++; $display("FAIL midreset_in_ready: got %b want 1", rdy16); end
    push(1'b0, new_left, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      wait_fall();
      vectors++; if (sd16 !== new_left[15-i]) begin miscompares++; $display("FAIL midreset_sdata fall %0d: got %b want %b", i, sd16, new_left[15-i]); end
      vectors++; if (fs16 !== (i == 0)) begin miscompares++; $display("FAIL midreset_frame_start fall %0d: got %b want %b", i, fs16, (i == 0)); end
      vectors++; if (ur16 !== 1'b0) begin miscompares++; $display("FAIL midreset_underrun fall %0d: got %b want 0", i, ur16); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_frame;
    logic [15:0] next_left;
    logic        exp_lrck;
    int          n;
    exp_frame = 32'h9A6C_35CA;
    next_left = 16'h8421;
    do_reset();
    push(1'b0, exp_frame[31:16], exp_frame[15:0]);
    for (int i = 0; i < 10; i++) begin
      wait_fall();
      vectors++; if (sd16 !== exp_frame[31-i]) begin miscompares++; $display("FAIL stall_pre_sdata fall %0d: got %b want %b", i, sd16, exp_frame[31-i]); end
    end
    n = 0;
    while (!sclk && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    sclk_run = 1'b0;
    push(1'b0, next_left, 16'h0000);
    repeat (100) @(negedge clk_in);
    vectors++; if (sd16 !== exp_frame[22]) begin miscompares++; $display("FAIL stall_hold_sdata: got %b want %b", sd16, exp_frame[22]); end
    vectors++; if (lrck16 !== 1'b0) begin miscompares++; $display("FAIL stall_hold_lrck: got %b want 0", lrck16); end
    vectors++; if (fs16 !== 1'b0) begin miscompares++; $display("FAIL stall_hold_frame_start: got %b want 0", fs16); end
    sclk_run = 1'b1;
    for (int i = 10; i < 32; i++) begin
      wait_fall();
      exp_lrck = (((i + 1) % 32) >= 16);
      vectors++; if (sd16 !== exp_frame[31-i]) begin miscompares++; $display("FAIL stall_post_sdata fall %0d: got %b want %b", i, sd16, exp_frame[31-i]); end
      vectors++; if (lrck16 !== exp_lrck) begin miscompares++; $display("FAIL stall_post_lrck fall %0d: got %b want %b", i, lrck16, exp_lrck); end
    end
    wait_fall();
    vectors++; if (sd16 !== next_left[15]) begin miscompares++; $display("FAIL stall_next_msb: got %b want %b", sd16, next_left[15]); end
    vectors++; if (ur16 !== 1'b0) begin miscompares++; $display("FAIL stall_next_underrun: got %b want 0", ur16); end
    vectors++; if (fs16 !== 1'b1) begin miscompares++; $display("FAIL stall_next_frame_start: got %b want 1", fs16); end
  endtask

  initial begin
    l16 = '0; r16 = '0; v16 = 1'b0;
    l12 = '0; r12 = '0; v12 = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    test_reset();
    test_frame_pattern();
    test_underrun();
    test_back_to_back();
    test_narrow_word();
    test_reset_mid_frame();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
